mem_fifo_ctrl: RTL
==================

// Module: mem_fifo_ctrl
// PURPOSE
//  FIFO controller upstream of the single-port sync RAM (addr/we/oe, registered read).
//  Turns push/pop requests into one RAM access per cycle: write/read pointers,
//  occupancy count, flags and sticky error bits.
//  Arbitrates simultaneous push/pop, since the RAM cannot read and write in the same cycle.
// PARAMETERS
//  DATA_WIDTH  6    word width; matches the RAM data bus
//  ADDR_WIDTH  8    RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH
//  AF_THRESH   252  almost_full when count >= AF_THRESH
//  AE_THRESH   4    almost_empty when count <= AE_THRESH
// PORTS
//  clk           in   1            clock; all state updates on posedge
//  reset         in   1            synchronous, active-high
//  push          in   1            write request
//  push_data     in   DATA_WIDTH   write word
//  push_ready    out  1            push accepted this cycle iff push && push_ready
//  pop           in   1            read request
//  pop_ready     out  1            pop accepted this cycle iff pop && pop_ready
//  pop_data      out  DATA_WIDTH   read word; = mem_rdata, meaningful only while pop_valid
//  pop_valid     out  1            read word present (1 cycle after pop accepted)
//  flush         in   1            synchronous clear of pointers/count
//  full          out  1            count == DEPTH
//  empty         out  1            count == 0
//  almost_full   out  1
//  almost_empty  out  1
//  count         out  ADDR_WIDTH+1 occupancy, 0..DEPTH
//  overflow      out  1            sticky: push while full
//  underflow     out  1            sticky: pop while empty
//  mem_addr      out  ADDR_WIDTH   RAM address (combinational from grant)
//  mem_we        out  1            RAM write enable
//  mem_oe        out  1            RAM output enable
//  mem_wdata     out  DATA_WIDTH   RAM write data = push_data
//  mem_rdata     in   DATA_WIDTH   RAM registered read data
// BEHAVIOUR
//  Reset (sync, active-high): wr_ptr = rd_ptr = count = 0; pop_valid = 0;
//   overflow = underflow = 0; last_grant = READ (so the first contended cycle grants WRITE).
//  Flags are derived from registered count: after reset empty = 1, almost_empty = 1, others 0.
//  Legality: wr_ok = !full, rd_ok = !empty (evaluated on registered count).
//  Arbitration, one access per cycle:
//   - only push && wr_ok -> WRITE
//   - only pop && rd_ok -> READ
//   - both legal -> grant opposite of last_grant; last_grant updates on every grant
//   - push_ready = wr_ok && !(pop && rd_ok && last_grant == WRITE)
//   - pop_ready mirrors this
//   - ready depends combinationally on the opposite request.
//  WRITE cycle: mem_we = 1, mem_oe = 0, mem_addr = wr_ptr;
//   on the edge wr_ptr += 1 (mod DEPTH wrap) and count += 1.
//  READ cycle: mem_we = 0, mem_oe = 1, mem_addr = rd_ptr;
//   on the edge rd_ptr += 1 (wrap) and count -= 1.
//   pop_valid = 1 in the next cycle only; pop_data = mem_rdata. Latency 1.
//  No grant: mem_we = mem_oe = 0, mem_addr = 0.
//  Overflow/underflow: push && full sets overflow; pop && empty sets underflow.
//   Request ignored, no RAM access, state unchanged. Bits cleared only by reset (not by flush).
//  Flush: highest priority below reset. No grant that cycle (mem_we = mem_oe = 0,
//   push_ready = pop_ready = 0); ptrs/count -> 0; pop_valid -> 0 next cycle.
//  Reset or flush the cycle after a READ grant: pop_valid forced 0; read data discarded.
//  count never exceeds DEPTH and never underflows. full and empty are never both 1.
// TESTING
//  1 Reset: hold reset 2 cycles -> empty=1, almost_empty=1, count=0, full=0,
//    mem_we=mem_oe=0, errors=0.
//  2 Push 256 words 0,1,2..63 (mod 64) -> count=256, full=1, almost_full from count 252;
//    push again -> overflow=1, no mem_we.
//  3 Drain: pop 256 times -> pop_valid 1 cycle after each pop, data in order, empty=1;
//    extra pop -> underflow=1.
//  4 Contention: count=10, push=pop=1 for 6 cycles -> grants W,R,W,R,W,R; count stays 10,
//    order preserved.
//  5 Wrap: 300 push/pop pairs, pointers cross 255->0 -> data order intact, count correct.
//  6 Flush mid-stream at count=5 with pop granted prior cycle -> pop_valid=0,
//    count=0, empty=1; sticky errors unchanged.

Source files
------------

// File: rtl/mem_fifo_ctrl.sv
// rtl/mem_fifo_ctrl.sv - FIFO controller for a single-port sync RAM, one RAM access per cycle
module mem_fifo_ctrl #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 8,
  parameter int AF_THRESH  = 252,
  parameter int AE_THRESH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  output logic                  o_push_ready,
  input  logic                  i_pop,
  output logic                  o_pop_ready,
  output logic [DATA_WIDTH-1:0] o_pop_data,
  output logic                  o_pop_valid,
  input  logic                  i_flush,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic                  o_mem_oe,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_e;

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_pop_valid;
  logic                  r_overflow;
  logic                  r_underflow;
  grant_e                r_last_grant;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;
  logic w_push_ready;
  logic w_pop_ready;
  logic w_wr_grant;
  logic w_rd_grant;

  assign w_full  = (r_count == (ADDR_WIDTH+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_wr_ok = !w_full;
  assign w_rd_ok = !w_empty;

  // When both sides are legal, the side granted last time yields.
  assign w_push_ready = w_wr_ok && !i_flush && !(i_pop && w_rd_ok && r_last_grant == GRANT_WRITE);
  assign w_pop_ready  = w_rd_ok && !i_flush && !(i_push && w_wr_ok && r_last_grant == GRANT_READ);
  assign w_wr_grant   = i_push && w_push_ready;
  assign w_rd_grant   = i_pop && w_pop_ready;

  assign o_push_ready   = w_push_ready;
  assign o_pop_ready    = w_pop_ready;
  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (r_count >= (ADDR_WIDTH+1)'(AF_THRESH));
  assign o_almost_empty = (r_count <= (ADDR_WIDTH+1)'(AE_THRESH));
  assign o_count        = r_count;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;
  assign o_mem_we       = w_wr_grant;
  assign o_mem_oe       = w_rd_grant;
  assign o_mem_wdata    = i_push_data;
  assign o_pop_data     = i_mem_rdata;
  // A flush or reset landing on the data cycle discards the word in flight.
  assign o_pop_valid    = r_pop_valid && !i_flush && !i_reset;

  always_comb begin
    o_mem_addr = '0;
    if (w_wr_grant) begin
      o_mem_addr = r_wr_ptr;
    end else if (w_rd_grant) begin
      o_mem_addr = r_rd_ptr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_pop_valid  <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_last_grant <= GRANT_READ;
    end else begin
      if (i_push && w_full) begin
        r_overflow <= 1'b1;
      end
      if (i_pop && w_empty) begin
        r_underflow <= 1'b1;
      end
      if (i_flush) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_pop_valid <= 1'b0;
      end else begin
        r_pop_valid <= w_rd_grant;
        if (w_wr_grant) begin
          r_wr_ptr     <= r_wr_ptr + ADDR_WIDTH'(1);
          r_count      <= r_count + (ADDR_WIDTH+1)'(1);
          r_last_grant <= GRANT_WRITE;
        end else if (w_rd_grant) begin
          r_rd_ptr     <= r_rd_ptr + ADDR_WIDTH'(1);
          r_count      <= r_count - (ADDR_WIDTH+1)'(1);
          r_last_grant <= GRANT_READ;
        end
      end
    end
  end

endmodule
